// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data requester ports and memory backend port of the arbiter
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ready_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ready_o;
  logic [31:0] dm_rdata_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;

  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_ack_i, mem_rdata_i,
    output if_ready_o, if_rdata_o, dm_ready_o, dm_rdata_o, err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
  );

  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_ack_i, mem_rdata_i,
    input  if_ready_o, if_rdata_o, dm_ready_o, dm_rdata_o, err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/DM arbiter onto one variable-latency memory, data priority with fetch anti-starvation
module mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_e      state_q, state_d;
  logic        owner_dm_q, owner_dm_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        dm_wins;
  logic [31:0] win_addr;

  // Data wins unless a pending fetch has already watched MAX_DATA_STREAK data grants go by.
  assign dm_wins  = bus.dm_req_i && !(bus.if_req_i && (streak_q == STREAK_MAX));
  assign win_addr = dm_wins ? bus.dm_addr_i : bus.if_addr_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_dm_q <= 1'b0;
      streak_q   <= 4'd0;
      addr_q     <= 32'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    streak_d   = streak_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.if_req_i || bus.dm_req_i) begin
          owner_dm_d = dm_wins;
          addr_d     = win_addr;
          if (dm_wins) begin
            we_d    = bus.dm_we_i;
            wdata_d = bus.dm_wdata_i;
            if (bus.if_req_i)
              streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
            else
              streak_d = 4'd0;
          end else begin
            we_d     = 1'b0;
            wdata_d  = 32'd0;
            streak_d = 4'd0;
          end
          // Misaligned accesses never reach the backend; they complete with an error.
          if (win_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = RESP;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.mem_ack_i) begin
          rdata_d = we_q ? 32'd0 : bus.mem_rdata_i;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_req_o   = (state_q == BUSY);
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.if_ready_o  = (state_q == RESP) && !owner_dm_q;
  assign bus.dm_ready_o  = (state_q == RESP) && owner_dm_q;
  assign bus.if_rdata_o  = rdata_q;
  assign bus.dm_rdata_o  = rdata_q;
  assign bus.err_o       = err_q;
  assign bus.stall_o     = (bus.if_req_i && !bus.if_ready_o) || (bus.dm_req_i && !bus.dm_ready_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] mrd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_mem;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0;
    int busy_idx = 0;
    int mem_cyc = 0;
    int lat = -1;
    logic got = 1'b0;
    logic stall_ok = 1'b1;
    logic bus_ok = 1'b1;
    logic other_ok = 1'b1;
    logic [31:0] rd = 32'hFFFF_FFFF;
    logic er = 1'bx;
    @(negedge clk);
    if (v.is_dm) begin
      bus.dm_req_i = 1'b1; bus.dm_we_i = v.we; bus.dm_addr_i = v.addr; bus.dm_wdata_i = v.wdata;
    end else begin
      bus.if_req_i = 1'b1; bus.if_addr_i = v.addr;
    end
    #1;
    while (!got && cyc < 60) begin
      if (v.is_dm ? bus.dm_ready_o : bus.if_ready_o) begin
        got = 1'b1;
        lat = cyc;
        rd  = v.is_dm ? bus.dm_rdata_o : bus.if_rdata_o;
        er  = bus.err_o;
        if (bus.stall_o !== 1'b0) stall_ok = 1'b0;
      end else if (bus.stall_o !== 1'b1) stall_ok = 1'b0;
      if ((v.is_dm ? bus.if_ready_o : bus.dm_ready_o) !== 1'b0) other_ok = 1'b0;
      if (bus.mem_req_o) begin
        mem_cyc++;
        if (bus.mem_addr_o !== v.addr || bus.mem_we_o !== (v.is_dm & v.we) ||
            bus.mem_wdata_o !== (v.is_dm ? v.wdata : 32'd0)) bus_ok = 1'b0;
        if (busy_idx == v.delay) begin
          bus.mem_ack_i = 1'b1; bus.mem_rdata_i = v.mrd;
        end else begin
          bus.mem_ack_i = 1'b0; bus.mem_rdata_i = 32'h0BAD_0BAD;
        end
        busy_idx++;
      end else bus.mem_ack_i = 1'b0;
      if (!got) begin
        @(negedge clk);
        cyc++;
      end
    end
    bus.if_req_i = 1'b0; bus.dm_req_i = 1'b0; bus.mem_ack_i = 1'b0;
    if (!got) $display("FAIL vec%0d_timeout: no ready within %0d cycles", idx, cyc);
    check($sformatf("vec%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("vec%0d_rdata", idx), rd, v.exp_rdata);
    check($sformatf("vec%0d_err", idx), {31'd0, er}, {31'd0, v.exp_err});
    check($sformatf("vec%0d_mem_cycles", idx), mem_cyc, v.exp_mem);
    check($sformatf("vec%0d_stall", idx), {31'd0, stall_ok}, 32'd1);
    check($sformatf("vec%0d_bus_stable", idx), {31'd0, bus_ok}, 32'd1);
    check($sformatf("vec%0d_other_ready", idx), {31'd0, other_ok}, 32'd1);
  endtask

  initial begin
    logic [7:0] order[6];
    string      exp_order;
    int         n;
    int         cyc;
    logic       quiet;

    // is_dm we addr wdata delay mrd exp_rdata exp_err exp_lat exp_mem
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h8C22_0004, 32'h8C22_0004, 1'b0, 2, 1};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 3, 32'h1234_5678, 32'h0, 1'b0, 5, 4};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 3, 2};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0022, 32'h0, 0, 32'h5555_5555, 32'h0, 1'b1, 1, 0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h5555_5555, 32'h0, 1'b1, 1, 0};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0021, 32'h1111_2222, 0, 32'h5555_5555, 32'h0, 1'b1, 1, 0};
    vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 2, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 4, 3};

    bus.if_req_i = 1'b0; bus.if_addr_i = 32'd0;
    bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'd0; bus.dm_wdata_i = 32'd0;
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = 32'd0;

    repeat (2) @(negedge clk);
    check("reset_outputs_zero", {31'd0, |{bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o,
          bus.if_ready_o, bus.dm_ready_o, bus.if_rdata_o, bus.dm_rdata_o, bus.err_o}}, 32'd0);
    check("reset_stall", {31'd0, bus.stall_o}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Both requesters busy; data keeps re-requesting, so fetch gets in after four data grants.
    exp_order = "DDDDID";
    for (int i = 0; i < 6; i++) order[i] = 8'h00;
    @(negedge clk);
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h200;
    #1;
    check("grant_stall_start", {31'd0, bus.stall_o}, 32'd1);
    n = 0; cyc = 0;
    while (n < 6 && cyc < 200) begin
      if (bus.mem_req_o) begin bus.mem_ack_i = 1'b1; bus.mem_rdata_i = bus.mem_addr_o; end
      else bus.mem_ack_i = 1'b0;
      if (bus.dm_ready_o) begin order[n] = "D"; n++; end
      if (bus.if_ready_o) begin order[n] = "I"; n++; bus.if_req_i = 1'b0; end
      if (n < 6) begin @(negedge clk); cyc++; end
    end
    bus.dm_req_i = 1'b0; bus.if_req_i = 1'b0; bus.mem_ack_i = 1'b0;
    for (int i = 0; i < 6; i++) check($sformatf("grant_order_%0d", i), {24'd0, order[i]}, {24'd0, exp_order[i]});

    // Reset while the backend access is outstanding, then a late ack.
    @(negedge clk);
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h80;
    @(negedge clk);
    check("midbusy_mem_req", {31'd0, bus.mem_req_o}, 32'd1);
    rst = 1'b1;
    #1;
    bus.dm_req_i = 1'b0;
    check("midbusy_reset_zero", {31'd0, |{bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o,
          bus.if_ready_o, bus.dm_ready_o, bus.if_rdata_o, bus.dm_rdata_o, bus.err_o}}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h7777_7777;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.dm_ready_o || bus.if_ready_o || bus.mem_req_o) quiet = 1'b0;
    end
    bus.mem_ack_i = 1'b0;
    check("late_ack_ignored", {31'd0, quiet}, 32'd1);

    // Single spurious ack pulse while idle.
    @(negedge clk);
    bus.mem_ack_i = 1'b1;
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.dm_ready_o || bus.if_ready_o || bus.mem_req_o || bus.stall_o) quiet = 1'b0;
    end
    check("spurious_ack_idle", {31'd0, quiet}, 32'd1);

    // Still arbitrates normally afterwards.
    run_vec(7, vecs[2]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
